// File: rtl/arith_unit_seq.sv
// Switch-operand arithmetic unit: add, subtract, accumulate (single cycle) and
// iterative shift-add multiply, with 7-segment digit buses for operands and result.

module hex22digit (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    // Active-high segments, bit 0 = a ... bit 6 = g
    always_comb begin
        case (hex_i)
            4'h0:    seg_o = 7'h3F;
            4'h1:    seg_o = 7'h06;
            4'h2:    seg_o = 7'h5B;
            4'h3:    seg_o = 7'h4F;
            4'h4:    seg_o = 7'h66;
            4'h5:    seg_o = 7'h6D;
            4'h6:    seg_o = 7'h7D;
            4'h7:    seg_o = 7'h07;
            4'h8:    seg_o = 7'h7F;
            4'h9:    seg_o = 7'h6F;
            4'hA:    seg_o = 7'h77;
            4'hB:    seg_o = 7'h7C;
            4'hC:    seg_o = 7'h39;
            4'hD:    seg_o = 7'h5E;
            4'hE:    seg_o = 7'h79;
            default: seg_o = 7'h71;
        endcase
    end
endmodule

module arith_unit_seq #(
    parameter int WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   op_valid,
    input  logic [1:0]             op_sel,
    input  logic [WIDTH-1:0]       switch_a,
    input  logic [WIDTH-1:0]       switch_b,
    output logic [2*WIDTH-1:0]     result,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic                   negative,
    output logic [7*WIDTH/4-1:0]   digits_a,
    output logic [7*WIDTH/4-1:0]   digits_b,
    output logic [7*WIDTH/2-1:0]   digits_res
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    logic [0:0]         state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               done_q,   done_d;
    logic               ovf_q,    ovf_d;
    logic               neg_q,    neg_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic [2*WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q,   prod_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [2*WIDTH:0]   acc_sum;
    logic [2*WIDTH-1:0] step;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = a_q - b_q;
        acc_sum = {1'b0, result_q} + {{(WIDTH+1){1'b0}}, a_q};
        step    = prod_q + (mplier_q[0] ? mcand_q : '0);

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;

        if (state_q == S_IDLE) begin
            a_d = switch_a;
            b_d = switch_b;
            if (op_valid) begin
                case (op_sel)
                    OP_ADD: begin
                        result_d = {{(WIDTH-1){1'b0}}, sum};
                        ovf_d    = sum[WIDTH];
                        neg_d    = 1'b0;
                        done_d   = 1'b1;
                    end
                    OP_SUB: begin
                        result_d = {{WIDTH{1'b0}}, diff};
                        ovf_d    = 1'b0;
                        neg_d    = (a_q < b_q);
                        done_d   = 1'b1;
                    end
                    OP_ACC: begin
                        result_d = acc_sum[2*WIDTH-1:0];
                        ovf_d    = acc_sum[2*WIDTH];
                        neg_d    = 1'b0;
                        done_d   = 1'b1;
                    end
                    default: begin
                        state_d  = S_MUL;
                        cnt_d    = '0;
                        prod_d   = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a_q};
                        mplier_d = b_q;
                    end
                endcase
            end
        end else begin
            // One multiplier bit per cycle; the last step's sum goes straight to result
            prod_d   = step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                result_d = step;
                ovf_d    = 1'b0;
                neg_d    = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign result   = result_q;
    assign busy     = (state_q == S_MUL);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign negative = neg_q;

    for (genvar i = 0; i < WIDTH/4; i++) begin : g_op_digits
        hex22digit u_dig_a (.hex_i(a_q[4*i +: 4]), .seg_o(digits_a[7*i +: 7]));
        hex22digit u_dig_b (.hex_i(b_q[4*i +: 4]), .seg_o(digits_b[7*i +: 7]));
    end

    for (genvar i = 0; i < WIDTH/2; i++) begin : g_res_digits
        hex22digit u_dig_r (.hex_i(result_q[4*i +: 4]), .seg_o(digits_res[7*i +: 7]));
    end
endmodule
